// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, sizing helpers and saturation for conv2d_mc
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  // Width of the intermediate used by sat_signed; comfortably wider than any accumulator.
  localparam int SAT_W = 64;

  // Output map dimension; a degenerate configuration yields 1 so elaboration reaches its checks.
  function automatic int conv_out_dim(input int size, input int k, input int stride);
    if (stride < 1 || size < k) return 1;
    return (size - k) / stride + 1;
  endfunction

  // Index width needed to address an array of n entries (never below one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clamp a sign-extended accumulator value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                          input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_window_addr.sv
// rtl/conv_window_addr.sv - output-pixel and kernel-tap counters with absolute input indices
module conv_window_addr
  import conv_pkg::*;
#(
  parameter int SIZE   = 7,
  parameter int K      = 3,
  parameter int CH     = 2,
  parameter int STRIDE = 1,
  parameter int OUT    = 5,
  localparam int SW    = idx_w(SIZE),
  localparam int KW    = idx_w(K),
  localparam int CW    = idx_w(CH),
  localparam int OW    = idx_w(OUT)
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          clear_i,
  input  logic          tap_adv_i,
  input  logic          pix_adv_i,
  output logic [OW-1:0] row_o,
  output logic [OW-1:0] col_o,
  output logic [CW-1:0] ch_o,
  output logic [KW-1:0] kr_o,
  output logic [KW-1:0] kc_o,
  output logic [SW-1:0] in_r_o,
  output logic [SW-1:0] in_c_o,
  output logic          last_tap_o,
  output logic          last_pixel_o
);

  logic [OW-1:0] row_q, row_d, col_q, col_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;

  // Next counter values: taps step kc fastest, then kr, then channel; all wrap to zero after the last.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ch_d  = ch_q;
    kr_d  = kr_q;
    kc_d  = kc_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      ch_d  = '0;
      kr_d  = '0;
      kc_d  = '0;
    end else begin
      if (tap_adv_i) begin
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          if (kr_q == KW'(K - 1)) begin
            kr_d = '0;
            ch_d = (ch_q == CW'(CH - 1)) ? '0 : ch_q + 1'b1;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      if (pix_adv_i) begin
        if (col_q == OW'(OUT - 1)) begin
          col_d = '0;
          row_d = (row_q == OW'(OUT - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row_q <= '0;
      col_q <= '0;
      ch_q  <= '0;
      kr_q  <= '0;
      kc_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      ch_q  <= ch_d;
      kr_q  <= kr_d;
      kc_q  <= kc_d;
    end
  end

  // Absolute input coordinates of the current tap and the end-of-window/end-of-map flags.
  always_comb begin
    in_r_o       = SW'(int'(row_q) * STRIDE + int'(kr_q));
    in_c_o       = SW'(int'(col_q) * STRIDE + int'(kc_q));
    last_tap_o   = (ch_q == CW'(CH - 1)) && (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
    last_pixel_o = (row_q == OW'(OUT - 1)) && (col_q == OW'(OUT - 1));
  end

  assign row_o = row_q;
  assign col_o = col_q;
  assign ch_o  = ch_q;
  assign kr_o  = kr_q;
  assign kc_o  = kc_q;

endmodule

// File: rtl/conv2d_mc.sv
// rtl/conv2d_mc.sv - multi-channel strided 2D convolution, serial MAC; CONV2D_MC_RELU_EN enables ReLU
module conv2d_mc
  import conv_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter int K         = 3,
  parameter int CH        = 2,
  parameter int STRIDE    = 1,
  parameter int WIDTH_BIT = 8,
  parameter int SHIFT     = 1,
  localparam int OUT      = conv_out_dim(SIZE, K, STRIDE)
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI [CH][SIZE][SIZE],
  input  logic signed [WIDTH_BIT-1:0] kernel     [CH][K][K],
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  output logic        [WIDTH_BIT-1:0] out_row,
  output logic        [WIDTH_BIT-1:0] out_col,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic signed [WIDTH_BIT-1:0] convOut    [OUT][OUT]
);

  localparam int N     = CH * K * K;
  localparam int ACC_W = 2 * WIDTH_BIT + $clog2(N);
  localparam int SW    = idx_w(SIZE);
  localparam int KW    = idx_w(K);
  localparam int CW    = idx_w(CH);
  localparam int OW    = idx_w(OUT);

  if (SIZE < K) begin : g_err_size
    $error("conv2d_mc: SIZE must be at least K");
  end else if (STRIDE < 1) begin : g_err_stride
    $error("conv2d_mc: STRIDE must be at least 1");
  end else if (((SIZE - K) % STRIDE) != 0) begin : g_err_fit
    $error("conv2d_mc: (SIZE-K) must be a multiple of STRIDE");
  end

  conv_state_t state_q, state_d;
  logic accept, tap_adv, pix_adv;

  logic [OW-1:0] row, col;
  logic [CW-1:0] ch;
  logic [KW-1:0] kr, kc;
  logic [SW-1:0] in_r, in_c;
  logic          last_tap, last_pixel;

  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_W-1:0]       acc_q, acc_d, acc_shr, acc_rect;
  logic signed [SAT_W-1:0]       sat_full;
  logic signed [WIDTH_BIT-1:0]   result;

  logic                        busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic        [WIDTH_BIT-1:0] row_q, row_d, col_q, col_d;
  logic signed [WIDTH_BIT-1:0] data_q, data_d;
  logic signed [WIDTH_BIT-1:0] conv_q [OUT][OUT];

  conv_window_addr #(
    .SIZE   (SIZE),
    .K      (K),
    .CH     (CH),
    .STRIDE (STRIDE),
    .OUT    (OUT)
  ) u_addr (
    .clock        (clock),
    .nreset       (nreset),
    .clear_i      (accept),
    .tap_adv_i    (tap_adv),
    .pix_adv_i    (pix_adv),
    .row_o        (row),
    .col_o        (col),
    .ch_o         (ch),
    .kr_o         (kr),
    .kc_o         (kc),
    .in_r_o       (in_r),
    .in_c_o       (in_c),
    .last_tap_o   (last_tap),
    .last_pixel_o (last_pixel)
  );

  // Current tap product and the rescaled, optionally rectified, saturated pixel value.
  always_comb begin
    prod    = inpMatrixI[ch][in_r][in_c] * kernel[ch][kr][kc];
    acc_shr = acc_q >>> SHIFT;
`ifdef CONV2D_MC_RELU_EN
    acc_rect = acc_shr[ACC_W-1] ? '0 : acc_shr;
`else
    acc_rect = acc_shr;
`endif
    sat_full = sat_signed(SAT_W'(acc_rect), WIDTH_BIT);
    result   = sat_full[WIDTH_BIT-1:0];
  end

  // Next state and per-state control strobes; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tap_adv = 1'b0;
    pix_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        tap_adv = 1'b1;
        if (last_tap) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        pix_adv = 1'b1;
        state_d = last_pixel ? ST_DONE : ST_MAC;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator and output-register next values; busy falls the cycle after the done pulse.
  always_comb begin
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    if (done_q) busy_d = 1'b0;
    if (accept) begin
      acc_d  = '0;
      busy_d = 1'b1;
    end
    if (tap_adv) acc_d = acc_q + ACC_W'(prod);
    if (pix_adv) begin
      acc_d   = '0;
      valid_d = 1'b1;
      row_d   = WIDTH_BIT'(row);
      col_d   = WIDTH_BIT'(col);
      data_d  = result;
    end
    if (state_q == ST_DONE) done_d = 1'b1;
  end

  // State, accumulator, handshake and pixel-stream registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  // Result map: each entry is written on its WRITE edge and kept until overwritten by a later run.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int r = 0; r < OUT; r++) begin
        for (int c = 0; c < OUT; c++) begin
          conv_q[r][c] <= '0;
        end
      end
    end else if (pix_adv) begin
      conv_q[row][col] <= result;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_data  = data_q;
  assign convOut   = conv_q;

endmodule

// File: doc/conv2d_mc.md
# conv2d_mc

Multi-channel, strided 2D convolution engine with start/done handshake: slides a K×K window over a CH×SIZE×SIZE signed input with step STRIDE, accumulates CH·K·K products per output pixel with a single serial MAC, then rescales, optionally rectifies, saturates and stores each pixel. Next-generation replacement for the single-channel 3-phase convolution wrapper; feeds pooling/next-layer blocks through the full output array or the per-pixel stream.

## Interface
- SIZE, 7, input height/width
- K, 3, kernel height/width
- CH, 2, input channels summed into one output map
- STRIDE, 1, window step (rows and columns)
- WIDTH_BIT, 8, signed data/weight width
- SHIFT, 1, arithmetic right shift applied to accumulator before saturation
- clock  in  1  rising-edge clock
- nreset  in  1  asynchronous, active-low reset
- start  in  1  request one full convolution; honoured only in IDLE
- inpMatrixI  in  [CH][SIZE][SIZE]×WIDTH_BIT  signed input; held stable while busy
- kernel  in  [CH][K][K]×WIDTH_BIT  signed weights; held stable while busy
- busy  out  1  high from cycle after accepted start until done pulse inclusive
- done  out  1  one-cycle pulse after last pixel written
- out_valid  out  1  one-cycle strobe per output pixel
- out_row, out_col  out  WIDTH_BIT each  coordinates of current out_data
- out_data  out  WIDTH_BIT  signed pixel value
- convOut  out  [OUT][OUT]×WIDTH_BIT  full result map, OUT=(SIZE-K)/STRIDE+1

## Operation
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: start=1 → MAC; row/col/tap counters and accumulator cleared. start=0 → stay.
- MAC: each cycle acc += inpMatrixI[c][row·STRIDE+kr][col·STRIDE+kc]·kernel[c][kr][kc]; tap order kc fastest, then kr, then c. After N=CH·K·K taps → WRITE.
- WRITE: result = sat(acc >>> SHIFT); out_valid=1, out_data/out_row/out_col driven, convOut[row][col] updated same edge. Accumulator cleared. Last pixel (row=col=OUT-1) → DONE, else col++ (wrap to 0, row++) → MAC.
- DONE: done=1 one cycle → IDLE.
- Accumulator width ACC_W = 2·WIDTH_BIT + $clog2(N); never overflows. sat clamps to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1].
- start while not IDLE: ignored, no queueing. start in the DONE cycle: ignored.
- Reset (any state, async): state IDLE, busy/done/out_valid=0, out_row/out_col/out_data=0, convOut all 0, counters/acc 0.
- Elaboration $error if SIZE<K, STRIDE<1, or (SIZE-K)%STRIDE≠0.

## Timing
- start sampled at edge t in IDLE → MAC taps at t+1..t+N, WRITE strobe at t+N+1.
- Per-pixel period N+1 cycles; done high at cycle t+OUT²·(N+1)+1.
- convOut entries stable from their WRITE edge until next accepted start overwrites them; not cleared on start.
- New start accepted earliest the cycle after done.

## Configuration
- CONV2D_MC_RELU_EN defined: negative pre-saturation result forced to 0 before storage (ReLU).
- Undefined: signed result stored as-is after shift and saturation.

## Structure
- conv_pkg: state enum conv_state_t, function sat_signed (ACC_W→WIDTH_BIT), localparam helper for OUT computation.
- Sub-module conv_window_addr: row/col/c/kr/kc counters, last-tap and last-pixel flags, absolute input indices; top holds FSM, MAC, output regs.

## Test plan
- SIZE=7,K=3,CH=1,STRIDE=1,SHIFT=1, input and kernel all 1 → 25 strobes, every out_data=4 (9>>>1), done once.
- Kernel all -1, same input → with RELU_EN all 0; without, all -5.
- Input all 127, kernel all 127, CH=1 → every out_data=127 (saturated); input -128, kernel 127, no ReLU → -128.
- SIZE=7,K=3,STRIDE=2 → OUT=3, out_row/out_col sequence (0,0),(0,1),(0,2),(1,0)…(2,2), windows at columns 0/2/4.
- CH=2,K=3,SIZE=5 → N=18, done exactly 9·19+1=172 cycles after start; start pulses while busy ignored.
- nreset asserted mid-MAC → outputs zero immediately; fresh start gives full, correct result.
